instruction_fetch_unit: RTL and testbench

//  Fetch-side initiator for the 128-word combinational instruction memory: owns the PC,

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/fetch_queue.sv | 44 ++++
 rtl/instruction_fetch_unit.sv | 75 +++++++
 tb/tb_instruction_fetch_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - imem, redirect/halt and decode-side signals of the fetch unit
interface instruction_fetch_unit_if;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;

    modport master (
        output imem_address, out_valid, out_instruction, out_pc, out_pc_plus4, fault,
        input  imem_instruction, redirect, redirect_target, halt, out_ready
    );

    modport slave (
        input  imem_address, out_valid, out_instruction, out_pc, out_pc_plus4, fault,
        output imem_instruction, redirect, redirect_target, halt, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of {instr,pc} entries with flush and registered head
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/FSM owner that fetches from combinational imem into a fetch queue
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          QDEPTH     = 2,
    parameter int          IMEM_WORDS = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    fetch_state_t state;
    logic [31:0]  pc;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic         full;
    logic         empty;
    logic         in_range;
    logic         pop;
    logic         push;

    assign in_range   = (pc[31:2] < IMEM_LIMIT);
    assign pop        = !empty && bus.out_ready;
    // A full queue still accepts a push when its head leaves on the same edge.
    assign push       = (state == ST_RUN) && !bus.redirect && !bus.halt && in_range && (!full || pop);
    assign push_entry = '{instr: bus.imem_instruction, pc: pc};

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect),
        .push_data (push_entry),
        .head_data (head_entry),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            pc    <= RESET_PC & ~32'h3;
        end else if (bus.redirect) begin
            state <= ST_RUN;
            pc    <= bus.redirect_target & ~32'h3;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.halt)
                        state <= ST_HALTED;
                    else if (!in_range)
                        state <= ST_FAULT;
                    else if (push)
                        pc <= pc + PC_STEP;
                end
                default: ;
            endcase
        end
    end

    // Head fields read as zero while nothing valid is queued.
    assign bus.imem_address    = pc;
    assign bus.out_valid       = !empty;
    assign bus.out_instruction = empty ? NOP_WORD : head_entry.instr;
    assign bus.out_pc          = empty ? 32'h0 : head_entry.pc;
    assign bus.out_pc_plus4    = empty ? 32'h0 : head_entry.pc + PC_STEP;
    assign bus.fault           = (state == ST_FAULT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .QDEPTH     (2),
        .IMEM_WORDS (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input int idx);
        if (idx == 0) return 32'h2010_0001;
        if (idx == 1) return 32'h2011_0001;
        return 32'hA000_0000 | 32'(idx);
    endfunction

    assign bus.imem_instruction = (bus.imem_address[31:9] == 23'd0)
                                  ? word_at(int'(bus.imem_address[8:2])) : 32'hDEAD_BEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset               = 1'b1;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt            = 1'b0;
        bus.out_ready       = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_instr", bus.out_instruction, 32'h0);
        check_eq("rst_pc", bus.out_pc, 32'h0);
        check_eq("rst_pc4", bus.out_pc_plus4, 32'h0);
        check_eq("rst_fault", 32'(bus.fault), 32'd0);
        check_eq("rst_addr", bus.imem_address, 32'h0);

        // Streaming from reset
        reset = 1'b0;
        tick();
        check_eq("t1_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_pc0", bus.out_pc, 32'h0);
        check_eq("t1_instr0", bus.out_instruction, 32'h2010_0001);
        check_eq("t1_pc4", bus.out_pc_plus4, 32'h4);
        tick();
        check_eq("t1_pc1", bus.out_pc, 32'h4);
        check_eq("t1_instr1", bus.out_instruction, 32'h2011_0001);
        tick();
        check_eq("t1_pc2", bus.out_pc, 32'h8);

        // Backpressure fills the queue, then drains in order
        reset = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("t2_addr_hold", bus.imem_address, 32'h8);
        check_eq("t2_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("t2_order", bus.out_pc, 32'(4 * k));
            tick();
        end

        // Redirect with a full queue
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h43;
        tick();
        bus.redirect = 1'b0;
        check_eq("t3_valid0", 32'(bus.out_valid), 32'd0);
        check_eq("t3_addr", bus.imem_address, 32'h40);
        tick();
        check_eq("t3_pc", bus.out_pc, 32'h40);
        check_eq("t3_instr", bus.out_instruction, word_at(16));
        tick();
        check_eq("t3_stable", bus.out_pc, 32'h40);

        // End of imem raises fault
        bus.out_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h1F8;
        tick();
        bus.redirect = 1'b0;
        check_eq("t4_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("t4_pc126", bus.out_pc, 32'h1F8);
        check_eq("t4_instr126", bus.out_instruction, word_at(126));
        tick();
        check_eq("t4_pc127", bus.out_pc, 32'h1FC);
        check_eq("t4_instr127", bus.out_instruction, word_at(127));
        check_eq("t4_addr200", bus.imem_address, 32'h200);
        check_eq("t4_nofault", 32'(bus.fault), 32'd0);
        tick();
        check_eq("t4_fault", 32'(bus.fault), 32'd1);
        check_eq("t4_nopush", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("t4_addr_hold", bus.imem_address, 32'h200);
        check_eq("t4_still_empty", 32'(bus.out_valid), 32'd0);
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h0;
        tick();
        bus.redirect = 1'b0;
        check_eq("t4_fault_clr", 32'(bus.fault), 32'd0);
        check_eq("t4_valid_gap", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("t4_restart_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t4_restart_pc", bus.out_pc, 32'h0);

        // Halt at PC 0x10 drains the queue
        bus.out_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h8;
        tick();
        bus.redirect = 1'b0;
        tick();
        tick();
        check_eq("t5_addr10", bus.imem_address, 32'h10);
        check_eq("t5_head8", bus.out_pc, 32'h8);
        bus.halt = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.halt = 1'b0;
        check_eq("t5_headC", bus.out_pc, 32'hC);
        check_eq("t5_addr_frz", bus.imem_address, 32'h10);
        tick();
        check_eq("t5_drained", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("t5_halted_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t5_halted_addr", bus.imem_address, 32'h10);
        bus.halt = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h20;
        tick();
        bus.halt = 1'b0;
        bus.redirect = 1'b0;
        check_eq("t5_redir_addr", bus.imem_address, 32'h20);
        tick();
        check_eq("t5_run_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t5_run_pc", bus.out_pc, 32'h20);

        // Reset with a full stalled queue
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("t6_full_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_addr", bus.imem_address, 32'h0);
        check_eq("t6_fault", 32'(bus.fault), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
